seq_match_arbiter: RTL and testbench

SEQ_MATCH_ARBITER -- requirements
Module: seq_match_arbiter

---
 rtl/seq_match_arbiter.sv | 103 ++++++++++
 tb/tb_seq_match_arbiter.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/seq_match_arbiter.sv
// seq_match_arbiter: round-robin owner of a shared sequence detector; define SEQ_ARB_TIMEOUT_EN for the RUN watchdog.
module seq_match_arbiter #(
  parameter int TIMEOUT_CYC = 64,
  parameter int DONE_CODE = 4100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  req,
  input  logic [15:0] code_in,
  input  logic [3:0]  code_valid,
  output logic [3:0]  code_ready,
  output logic [3:0]  grant,
  output logic        det_rst,
  output logic [3:0]  det_in,
  input  logic [16:0] det_state,
  output logic [3:0]  match,
  output logic [3:0]  fail,
  output logic        timeout
);
  typedef enum logic [1:0] {IDLE, ARM, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [1:0] owner_q, owner_d, last_q, last_d, pick;
  logic [3:0] cnt_q, cnt_d, grant_q, grant_d, ready_q, ready_d;
  logic [3:0] match_q, match_d, fail_q, fail_d, det_in_q, det_in_d;
  logic det_rst_q, det_rst_d, xfer, is_done, is_fall, expire, to_d;
  assign xfer = state_q == RUN && |(code_valid & ready_q);
  assign is_done = det_state == 17'(DONE_CODE);
  assign is_fall = det_state == '0 && cnt_q >= 4'd2;
  // Walk downward so the requester nearest last_owner+1 is assigned last and wins.
  always_comb begin
    pick = last_q;
    for (int k = 4; k >= 1; k--) if (req[last_q + 2'(k)]) pick = last_q + 2'(k);
  end
`ifdef SEQ_ARB_TIMEOUT_EN
  localparam int IW = $clog2(TIMEOUT_CYC + 1);
  logic [IW-1:0] idle_q, idle_d;
  logic to_q;
  assign expire = state_q == RUN && !xfer && idle_q == IW'(TIMEOUT_CYC - 1);
  assign idle_d = (state_q == RUN && !xfer) ? idle_q + IW'(1) : '0;
  assign timeout = to_q;
  always_ff @(posedge clk) begin
    idle_q <= reset ? '0 : idle_d;
    to_q <= reset ? 1'b0 : to_d;
  end
`else
  assign expire = 1'b0;
  assign timeout = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q <= 2'd3;
      cnt_q <= '0;
      grant_q <= '0;
      ready_q <= '0;
      match_q <= '0;
      fail_q <= '0;
      det_in_q <= '0;
      det_rst_q <= 1'b1;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q <= last_d;
      cnt_q <= cnt_d;
      grant_q <= grant_d;
      ready_q <= ready_d;
      match_q <= match_d;
      fail_q <= fail_d;
      det_in_q <= det_in_d;
      det_rst_q <= det_rst_d;
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: state_d = |req ? ARM : IDLE;
      ARM:  state_d = RUN;
      RUN:  state_d = (is_done || is_fall || expire || !req[owner_q]) ? DONE : RUN;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // Completion outranks fall-back, which outranks the watchdog.
  always_comb begin
    owner_d = (state_q == IDLE && |req) ? pick : owner_q;
    last_d = state_q == DONE ? owner_q : last_q;
    grant_d = (state_d == ARM || state_d == RUN) ? 4'b1 << owner_d : '0;
    ready_d = state_d == RUN ? 4'b1 << owner_d : '0;
    match_d = (state_q == RUN && is_done) ? grant_q : '0;
    fail_d = (state_q == RUN && !is_done && (is_fall || expire)) ? grant_q : '0;
    to_d = state_q == RUN && !is_done && !is_fall && expire;
    det_rst_d = state_d == ARM || state_d == DONE;
    det_in_d = state_d == ARM ? '0 : xfer ? code_in[{owner_q, 2'b00} +: 4] : det_in_q;
    cnt_d = state_q == ARM ? '0 : (xfer && cnt_q != 4'hF) ? cnt_q + 4'd1 : cnt_q;
  end
  assign code_ready = ready_q;
  assign grant = grant_q;
  assign det_rst = det_rst_q;
  assign det_in = det_in_q;
  assign match = match_q;
  assign fail = fail_q;
endmodule

// File: tb/tb_seq_match_arbiter.sv
// tb_seq_match_arbiter: directed checks of arbitration, session flow, pulses and watchdog.
module tb_seq_match_arbiter;
  logic clk = 1'b0, reset = 1'b1;
  logic [3:0] req = '0, code_valid = '0;
  logic [15:0] code_in = '0;
  logic [16:0] det_state = 17'd1;
  logic [3:0] code_ready, grant, det_in, match, fail;
  logic det_rst, timeout;
  logic [21:0] obs;
  int checks = 0, errors = 0;
  seq_match_arbiter #(.TIMEOUT_CYC(8), .DONE_CODE(4100)) dut (
    .clk(clk), .reset(reset), .req(req), .code_in(code_in), .code_valid(code_valid),
    .code_ready(code_ready), .grant(grant), .det_rst(det_rst), .det_in(det_in),
    .det_state(det_state), .match(match), .fail(fail), .timeout(timeout)
  );
  always #5 clk = ~clk;
  // obs = {grant, code_ready, det_rst, det_in, match, fail, timeout}
  assign obs = {grant, code_ready, det_rst, det_in, match, fail, timeout};
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    reset = 1'b1; req = '0; code_valid = '0; code_in = '0; det_state = 17'd1;
    tick; tick;
    reset = 1'b0;
    tick;
  endtask
  task automatic test_reset;
    reset = 1'b1;
    tick; tick;
    checks++; if (obs !== {4'b0000, 4'b0000, 1'b1, 4'h0, 4'b0000, 4'b0000, 1'b0}) begin errors++; $display("FAIL reset_hold obs=%h exp=%h", obs, {4'b0000, 4'b0000, 1'b1, 4'h0, 4'b0000, 4'b0000, 1'b0}); end
    reset = 1'b0;
    tick;
    checks++; if (obs !== 22'h0) begin errors++; $display("FAIL reset_idle obs=%h exp=%h", obs, 22'h0); end
  endtask
  task automatic test_basic;
    req = 4'b0001;
    tick;
    checks++; if (obs !== {4'b0001, 4'b0000, 1'b1, 4'h0, 4'b0000, 4'b0000, 1'b0}) begin errors++; $display("FAIL basic_arm obs=%h", obs); end
    tick;
    checks++; if (obs !== {4'b0001, 4'b0001, 1'b0, 4'h0, 4'b0000, 4'b0000, 1'b0}) begin errors++; $display("FAIL basic_run obs=%h", obs); end
    code_in = 16'hFFF5; code_valid = 4'b1111;
    tick;
    checks++; if (det_in !== 4'h5) begin errors++; $display("FAIL basic_load det_in=%h exp=5", det_in); end
    code_in = 16'h000A; code_valid = 4'b0000;
    tick;
    checks++; if (det_in !== 4'h5) begin errors++; $display("FAIL basic_hold det_in=%h exp=5", det_in); end
    code_valid = 4'b0001;
    tick;
    code_valid = 4'b0000; det_state = 17'd4100;
    tick;
    checks++; if (obs !== {4'b0000, 4'b0000, 1'b1, 4'hA, 4'b0001, 4'b0000, 1'b0}) begin errors++; $display("FAIL basic_match obs=%h", obs); end
    det_state = 17'd1; req = 4'b0000;
    tick;
    checks++; if (obs !== {4'b0000, 4'b0000, 1'b0, 4'hA, 4'b0000, 4'b0000, 1'b0}) begin errors++; $display("FAIL basic_idle obs=%h", obs); end
  endtask
  task automatic test_round_robin;
    logic [3:0] exp;
    do_reset;
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      exp = 4'b0001 << (i % 4);
      tick;
      checks++; if (grant !== exp) begin errors++; $display("FAIL rr_grant%0d grant=%b exp=%b", i, grant, exp); end
      tick;
      det_state = 17'd4100;
      tick;
      checks++; if (match !== exp) begin errors++; $display("FAIL rr_match%0d match=%b exp=%b", i, match, exp); end
      det_state = 17'd1;
      tick;
    end
    req = 4'b0000;
    tick;
  endtask
  task automatic test_fail;
    req = 4'b0001;
    tick; tick;
    det_state = 17'd200; code_valid = 4'b0001; code_in = 16'h0003;
    tick;
    code_in = 16'h0004;
    tick;
    code_valid = 4'b0000; det_state = 17'd0;
    tick;
    checks++; if (obs !== {4'b0000, 4'b0000, 1'b1, 4'h4, 4'b0000, 4'b0001, 1'b0}) begin errors++; $display("FAIL fail_pulse obs=%h", obs); end
    det_state = 17'd1;
    tick;
    checks++; if (fail !== 4'b0000) begin errors++; $display("FAIL fail_one_cycle fail=%b exp=0000", fail); end
    tick; tick;
    code_valid = 4'b0001; code_in = 16'h0007;
    tick;
    code_valid = 4'b0000; det_state = 17'd0;
    tick;
    checks++; if (obs !== {4'b0001, 4'b0001, 1'b0, 4'h7, 4'b0000, 4'b0000, 1'b0}) begin errors++; $display("FAIL fail_count1 obs=%h", obs); end
    det_state = 17'd1; code_valid = 4'b0001;
    tick;
    code_valid = 4'b0000; det_state = 17'd4100;
    tick;
    checks++; if (obs !== {4'b0000, 4'b0000, 1'b1, 4'h7, 4'b0001, 4'b0000, 1'b0}) begin errors++; $display("FAIL match_only obs=%h", obs); end
    det_state = 17'd1; req = 4'b0000;
    tick;
  endtask
  task automatic test_drop;
    req = 4'b0001;
    tick; tick;
    req = 4'b0000;
    tick;
    checks++; if (obs !== {4'b0000, 4'b0000, 1'b1, 4'h0, 4'b0000, 4'b0000, 1'b0}) begin errors++; $display("FAIL drop_done obs=%h", obs); end
    tick;
    checks++; if (obs !== 22'h0) begin errors++; $display("FAIL drop_idle obs=%h exp=0", obs); end
  endtask
  task automatic test_reset_mid;
    req = 4'b0001;
    tick; tick;
    code_valid = 4'b0001; code_in = 16'h0009;
    tick;
    code_valid = 4'b0000; reset = 1'b1;
    tick;
    checks++; if (obs !== {4'b0000, 4'b0000, 1'b1, 4'h0, 4'b0000, 4'b0000, 1'b0}) begin errors++; $display("FAIL rstmid obs=%h", obs); end
    reset = 1'b0; req = 4'b0000;
    tick;
    checks++; if (obs !== 22'h0) begin errors++; $display("FAIL rstmid_idle obs=%h exp=0", obs); end
  endtask
  task automatic test_timeout;
    req = 4'b0001;
    tick; tick;
    repeat (7) tick;
    checks++; if (obs !== {4'b0001, 4'b0001, 1'b0, 4'h0, 4'b0000, 4'b0000, 1'b0}) begin errors++; $display("FAIL to_before obs=%h", obs); end
`ifdef SEQ_ARB_TIMEOUT_EN
    req = 4'b0000;
    tick;
    checks++; if (obs !== {4'b0000, 4'b0000, 1'b1, 4'h0, 4'b0000, 4'b0001, 1'b1}) begin errors++; $display("FAIL to_fire obs=%h", obs); end
    tick;
`else
    repeat (20) tick;
    checks++; if (obs !== {4'b0001, 4'b0001, 1'b0, 4'h0, 4'b0000, 4'b0000, 1'b0}) begin errors++; $display("FAIL to_persist obs=%h", obs); end
    req = 4'b0000;
    tick;
    checks++; if (obs !== {4'b0000, 4'b0000, 1'b1, 4'h0, 4'b0000, 4'b0000, 1'b0}) begin errors++; $display("FAIL to_end obs=%h", obs); end
    tick;
`endif
  endtask
  initial begin
    test_reset;
    test_basic;
    test_round_robin;
    test_fail;
    test_drop;
    test_reset_mid;
    test_timeout;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
